// File: rtl/riscv_irq_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_irq_arbiter
//
// Collapses up to 32 external interrupt lines into the single request, 5-bit
// ID and secure flag used by the core interrupt controller. Each line is
// synchronised, qualified as edge or level, held pending (edge lines only),
// masked by the per-line enable, and the highest enabled index wins. The
// presented request stays frozen until the core acknowledges it or it is
// withdrawn. Every request is followed by one forced low cycle.
//
// Ports
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   irq_lines_i  raw asynchronous interrupt lines
//   irq_en_i     per-line enable mask
//   sw_clr_i     per-line one-cycle clear of edge pending bits
//   irq_ack_i    core accepted the presented interrupt
//   irq_o        request to the controller
//   irq_id_o     ID of the presented line (0 when not presenting)
//   irq_sec_o    secure attribute of the presented line (0 when not presenting)
//   pending_o    raw pending vector before enable masking
// -----------------------------------------------------------------------------
module riscv_irq_arbiter #(
    parameter int          N_IRQ       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EDGE_MASK   = 32'h0000_0000,
    parameter logic [31:0] SEC_MASK    = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_lines_i,
    input  logic [N_IRQ-1:0] irq_en_i,
    input  logic [N_IRQ-1:0] sw_clr_i,
    input  logic             irq_ack_i,
    output logic             irq_o,
    output logic [4:0]       irq_id_o,
    output logic             irq_sec_o,
    output logic [N_IRQ-1:0] pending_o
);

    // Lines above N_IRQ do not exist; mask them everywhere.
    localparam logic [31:0] VALID_MASK = (N_IRQ >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << N_IRQ) - 32'd1);
    localparam logic [31:0] EDGE_M     = EDGE_MASK & VALID_MASK;
    localparam logic [31:0] LEVEL_M    = ~EDGE_MASK & VALID_MASK;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    logic [31:0] raw_lines;
    logic [31:0] en_vec;
    logic [31:0] clr_vec;
    logic [31:0] sync_s;

    assign raw_lines = 32'(irq_lines_i);
    assign en_vec    = 32'(irq_en_i);
    assign clr_vec   = 32'(sw_clr_i);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync_s = raw_lines;
        end else begin : g_sync
            logic [31:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= raw_lines;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign sync_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge history, pending storage, selection and FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] hist_q, hist_d;
    logic [31:0] pend_edge_q, pend_edge_d;
    logic [4:0]  id_q, id_d;
    logic        sec_q, sec_d;

    logic [31:0] ack_clr;
    logic [31:0] edge_set;
    logic [31:0] pend_vec;
    logic [31:0] eff_vec;
    logic [4:0]  winner;

    assign hist_d = sync_s;

    always_comb begin
        ack_clr = '0;
        if (state_q == PRESENT && irq_ack_i) begin
            ack_clr[id_q] = 1'b1;
        end
        edge_set = sync_s & ~hist_q & EDGE_M;
        // A new edge in the same cycle as a clear keeps the bit pending.
        pend_edge_d = (edge_set | (pend_edge_q & ~(clr_vec | ack_clr))) & EDGE_M;
    end

    // Level lines bypass storage and follow the synchronised input.
    assign pend_vec = pend_edge_q | (sync_s & LEVEL_M);
    assign eff_vec  = pend_vec & en_vec;

    // Fixed priority: ascending scan so the highest set index is kept.
    always_comb begin
        winner = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (eff_vec[i]) begin
                winner = 5'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sec_d   = sec_q;
        unique case (state_q)
            IDLE: begin
                id_d  = 5'd0;
                sec_d = 1'b0;
                if (|eff_vec) begin
                    id_d    = winner;
                    sec_d   = SEC_MASK[winner];
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Ack takes precedence; otherwise drop if our line vanished.
                if (irq_ack_i || !eff_vec[id_q]) begin
                    id_d    = 5'd0;
                    sec_d   = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                id_d    = 5'd0;
                sec_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                id_d    = 5'd0;
                sec_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hist_q      <= '0;
            pend_edge_q <= '0;
            id_q        <= 5'd0;
            sec_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            pend_edge_q <= pend_edge_d;
            id_q        <= id_d;
            sec_q       <= sec_d;
        end
    end

    assign irq_o     = (state_q == PRESENT);
    assign irq_id_o  = id_q;
    assign irq_sec_o = sec_q;
    assign pending_o = pend_vec[N_IRQ-1:0];

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_irq_arbiter
//
// Scenario bench for riscv_irq_arbiter. Expected presentations (id, secure)
// are queued when a line is driven and popped when the DUT raises irq_o.
// -----------------------------------------------------------------------------
module tb_riscv_irq_arbiter;

    localparam int          N_IRQ = 32;
    localparam logic [31:0] EDGE  = 32'h0000_1030;   // lines 4, 5, 12 edge
    localparam logic [31:0] SEC   = 32'hFFEF_FFF7;   // lines 3, 20 non-secure

    typedef struct packed {
        logic [4:0] id;
        logic       sec;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_lines;
    logic [31:0] irq_en;
    logic [31:0] sw_clr;
    logic        irq_ack;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_sec_o;
    logic [31:0] pending_o;

    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];
    logic [31:0] sec_tab;

    riscv_irq_arbiter #(
        .N_IRQ      (N_IRQ),
        .SYNC_STAGES(2),
        .EDGE_MASK  (EDGE),
        .SEC_MASK   (SEC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_lines_i(irq_lines),
        .irq_en_i   (irq_en),
        .sw_clr_i   (sw_clr),
        .irq_ack_i  (irq_ack),
        .irq_o      (irq_o),
        .irq_id_o   (irq_id_o),
        .irq_sec_o  (irq_sec_o),
        .pending_o  (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 5'(id);
        e.sec = sec_tab[id];
        sb_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb_q.size() != 0);
        e  = '0;
        if (ok) e = sb_q.pop_front();
    endtask

    // Advance until irq_o is high or the budget runs out; n = edges taken.
    task automatic wait_irq(input int budget, output int n, output bit found);
        found = 1'b0;
        n     = 0;
        while (!found && n < budget) begin
            step();
            n++;
            if (irq_o) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t e; bit ok;
        rst_n = 1'b0; irq_lines = '0; irq_en = '0; sw_clr = '0; irq_ack = 1'b0;
        repeat (3) step();
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_irq got=%b want=0", irq_o); end
        tests_run++;
        if (irq_id_o !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_id got=%0d want=0", irq_id_o); end
        tests_run++;
        if (irq_sec_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sec got=%b want=0", irq_sec_o); end
        tests_run++;
        if (pending_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pending got=%h want=0", pending_o); end
        rst_n = 1'b1;
        step();
        pop_exp(e, ok);
        $display("[TB] reset released");
    endtask

    task automatic test_edge_basic();
        exp_t e; bit ok; bit found; int n;
        irq_en = '1;
        irq_lines[5] = 1'b1;
        push_exp(5);
        found = 1'b0; n = 0;
        while (!found && n < 10) begin
            step(); n++;
            if (n == 1) irq_lines[5] = 1'b0;
            if (irq_o) found = 1'b1;
        end
        tests_run++;
        if (!found || n != 4) begin tests_failed++; $display("[TB] FAIL edge_latency got=%0d found=%b want=4", n, found); end
        pop_exp(e, ok);
        tests_run++;
        if (!ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL edge_present got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        tests_run++;
        if (pending_o[5] !== 1'b1) begin tests_failed++; $display("[TB] FAIL edge_pending_set got=%b want=1", pending_o[5]); end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        tests_run++;
        if (irq_o !== 1'b0 || irq_id_o !== 5'd0) begin tests_failed++; $display("[TB] FAIL edge_ack_drop got irq=%b id=%0d want irq=0 id=0", irq_o, irq_id_o); end
        tests_run++;
        if (pending_o[5] !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_ack_clear got=%b want=0", pending_o[5]); end
        repeat (3) step();
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_no_repeat got=%b want=0", irq_o); end
    endtask

    task automatic test_priority();
        exp_t e; bit ok; bit found; int n; int low;
        irq_lines[3] = 1'b1; irq_lines[20] = 1'b1;
        push_exp(20); push_exp(3);
        wait_irq(10, n, found);
        tests_run++;
        if (!found || n != 3) begin tests_failed++; $display("[TB] FAIL level_latency got=%0d found=%b want=3", n, found); end
        pop_exp(e, ok);
        tests_run++;
        if (!ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL prio_first got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        irq_ack = 1'b1; irq_lines[20] = 1'b0; step(); irq_ack = 1'b0;
        low = 0;
        while (!irq_o && low < 10) begin low++; step(); end
        tests_run++;
        if (low != 2) begin tests_failed++; $display("[TB] FAIL prio_gap got=%0d want=2", low); end
        pop_exp(e, ok);
        tests_run++;
        if (!ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL prio_second got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        irq_ack = 1'b1; irq_lines[3] = 1'b0; step(); irq_ack = 1'b0;
        repeat (4) step();
        tests_run++;
        if (irq_o !== 1'b0 || pending_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL prio_idle got irq=%b pend=%h want 0/0", irq_o, pending_o); end
    endtask

    task automatic test_withdraw();
        exp_t e; bit ok; bit found; int n;
        irq_lines[7] = 1'b1;
        push_exp(7);
        wait_irq(10, n, found);
        pop_exp(e, ok);
        tests_run++;
        if (!found || !ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL wd_present got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        irq_lines[7] = 1'b0;
        n = 0;
        while (irq_o && n < 10) begin step(); n++; end
        tests_run++;
        if (n != 3) begin tests_failed++; $display("[TB] FAIL wd_latency got=%0d want=3", n); end
        step();
        tests_run++;
        if (irq_o !== 1'b0 || pending_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL wd_idle got irq=%b pend=%h want 0/0", irq_o, pending_o); end
    endtask

    task automatic test_enable();
        exp_t e; bit ok;
        irq_en[9] = 1'b0; irq_lines[9] = 1'b1;
        repeat (5) step();
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_masked got=%b want=0", irq_o); end
        tests_run++;
        if (pending_o[9] !== 1'b1) begin tests_failed++; $display("[TB] FAIL en_pending got=%b want=1", pending_o[9]); end
        push_exp(9);
        irq_en[9] = 1'b1; step();
        pop_exp(e, ok);
        tests_run++;
        if (!ok || irq_o !== 1'b1 || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL en_present got irq=%b id=%0d sec=%b want irq=1 id=%0d sec=%b", irq_o, irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        irq_ack = 1'b1; irq_lines[9] = 1'b0; step(); irq_ack = 1'b0;
        repeat (4) step();
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_idle got=%b want=0", irq_o); end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit ok; bit found; int n; int low;
        irq_lines[12] = 1'b1;
        push_exp(12);
        step(); irq_lines[12] = 1'b0;
        wait_irq(10, n, found);
        pop_exp(e, ok);
        tests_run++;
        if (!found || !ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL b2b_first got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        // Second edge reaches the synchroniser output in the ack cycle.
        irq_lines[12] = 1'b1; step(); step();
        irq_ack = 1'b1; irq_lines[12] = 1'b0; step(); irq_ack = 1'b0;
        tests_run++;
        if (pending_o[12] !== 1'b1 || irq_o !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL b2b_set_wins got pend=%b irq=%b want pend=1 irq=0", pending_o[12], irq_o);
        end
        push_exp(12);
        low = 0;
        while (!irq_o && low < 10) begin low++; step(); end
        tests_run++;
        if (low != 2) begin tests_failed++; $display("[TB] FAIL b2b_gap got=%0d want=2", low); end
        pop_exp(e, ok);
        tests_run++;
        if (!ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL b2b_again got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        tests_run++;
        if (pending_o[12] !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_clear got=%b want=0", pending_o[12]); end
        repeat (3) step();
    endtask

    task automatic test_swclr_reset();
        exp_t e; bit ok; bit found; int n;
        irq_lines[4] = 1'b1;
        push_exp(4);
        step(); irq_lines[4] = 1'b0;
        wait_irq(10, n, found);
        pop_exp(e, ok);
        tests_run++;
        if (!found || !ok || irq_id_o !== e.id || irq_sec_o !== e.sec) begin
            tests_failed++; $display("[TB] FAIL swclr_present got id=%0d sec=%b want id=%0d sec=%b", irq_id_o, irq_sec_o, e.id, e.sec);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        sw_clr[4] = 1'b1; step(); sw_clr[4] = 1'b0;
        tests_run++;
        if (pending_o[4] !== 1'b0 || irq_o !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL swclr_clear got pend=%b irq=%b want pend=0 irq=1", pending_o[4], irq_o);
        end
        step();
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL swclr_withdraw got=%b want=0", irq_o); end
        repeat (2) step();

        irq_lines[4] = 1'b1;
        push_exp(4);
        step(); irq_lines[4] = 1'b0;
        wait_irq(10, n, found);
        pop_exp(e, ok);
        tests_run++;
        if (!found || !ok || irq_id_o !== e.id) begin
            tests_failed++; $display("[TB] FAIL rst_present got id=%0d want id=%0d", irq_id_o, e.id);
        end
        $display("[TB] present id=%0d sec=%b", irq_id_o, irq_sec_o);
        // A higher level line must not disturb the presented ID.
        irq_lines[7] = 1'b1;
        repeat (3) step();
        tests_run++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd4) begin tests_failed++; $display("[TB] FAIL id_stable got irq=%b id=%0d want irq=1 id=4", irq_o, irq_id_o); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (irq_o !== 1'b0 || irq_id_o !== 5'd0 || irq_sec_o !== 1'b0 || pending_o !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL async_reset got irq=%b id=%0d sec=%b pend=%h want all 0", irq_o, irq_id_o, irq_sec_o, pending_o);
        end
        irq_lines[7] = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (irq_o !== 1'b0 || pending_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL post_reset got irq=%b pend=%h want 0/0", irq_o, pending_o); end
        $display("[TB] mid-operation reset done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sec_tab      = SEC;
        test_reset();
        test_edge_basic();
        test_priority();
        test_withdraw();
        test_enable();
        test_back_to_back();
        test_swclr_reset();
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("[TB] FAIL scoreboard_left got=%0d want=0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
